// File: rtl/bram_frame_writer_if.sv
// Byte-stream input, frame-buffer write port and frame ownership handshake
// for the frame writer.
interface bram_frame_writer_if #(
    parameter int ADDR_W = 8
);
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_sof;
    logic              s_eof;
    logic              s_ready;
    logic              bram_wr_en;
    logic [ADDR_W-1:0] bram_wr_addr;
    logic [31:0]       bram_wr_data;
    logic              frame_valid;
    logic [10:0]       frame_len;
    logic              frame_ovf;
    logic              frame_ack;
    logic              err_drop;
    logic              err_sof;

    modport master (
        output s_valid, s_data, s_sof, s_eof, frame_ack,
        input  s_ready, bram_wr_en, bram_wr_addr, bram_wr_data,
               frame_valid, frame_len, frame_ovf, err_drop, err_sof
    );

    modport slave (
        input  s_valid, s_data, s_sof, s_eof, frame_ack,
        output s_ready, bram_wr_en, bram_wr_addr, bram_wr_data,
               frame_valid, frame_len, frame_ovf, err_drop, err_sof
    );
endinterface

// File: rtl/bram_frame_writer.sv
// Packs a framed byte stream little-endian into 32-bit buffer words, then writes a length/status header at addr 0.
// Latency: word write 1 cycle after its last byte; header 2 cycles and frame_valid 3 cycles after the eof byte.
// Backpressure: s_ready drops from header write until frame_ack releases the buffer; no skid, bytes are held upstream.
module bram_frame_writer #(
    parameter int MAX_WORDS = 255,
    parameter int ADDR_W    = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    bram_frame_writer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, FILL, HDR, HOLD} state_t;

    localparam logic [ADDR_W-1:0] MAX_W = ADDR_W'(MAX_WORDS);

    state_t            state;
    logic [10:0]       byte_cnt;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       pack;
    logic [31:0]       word_next;
    logic              ovf;
    logic              accept;

    assign bus.s_ready = (state == IDLE) || (state == FILL);
    assign accept      = bus.s_valid && bus.s_ready;

    always_comb begin
        word_next = pack;
        case (byte_cnt[1:0])
            2'd0:    word_next[7:0]   = bus.s_data;
            2'd1:    word_next[15:8]  = bus.s_data;
            2'd2:    word_next[23:16] = bus.s_data;
            default: word_next[31:24] = bus.s_data;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state            <= IDLE;
            byte_cnt         <= '0;
            word_idx         <= '0;
            pack             <= '0;
            ovf              <= 1'b0;
            bus.bram_wr_en   <= 1'b0;
            bus.bram_wr_addr <= '0;
            bus.bram_wr_data <= '0;
            bus.frame_valid  <= 1'b0;
            bus.frame_len    <= '0;
            bus.frame_ovf    <= 1'b0;
            bus.err_drop     <= 1'b0;
            bus.err_sof      <= 1'b0;
        end else begin
            bus.bram_wr_en <= 1'b0;
            bus.err_drop   <= 1'b0;
            bus.err_sof    <= 1'b0;
            case (state)
                IDLE, FILL: begin
                    if (accept) begin
                        if (bus.s_sof) begin
                            // A sof inside FILL abandons the old frame, including its partial word.
                            bus.err_sof <= (state == FILL);
                            byte_cnt    <= 11'd1;
                            word_idx    <= '0;
                            ovf         <= 1'b0;
                            if (bus.s_eof) begin
                                bus.bram_wr_en   <= 1'b1;
                                bus.bram_wr_addr <= ADDR_W'(1);
                                bus.bram_wr_data <= {24'b0, bus.s_data};
                                word_idx         <= ADDR_W'(1);
                                pack             <= '0;
                                state            <= HDR;
                            end else begin
                                pack  <= {24'b0, bus.s_data};
                                state <= FILL;
                            end
                        end else if (state == IDLE) begin
                            bus.err_drop <= 1'b1;
                        end else begin
                            if (byte_cnt != 11'h7FF) byte_cnt <= byte_cnt + 11'd1;
                            // Full word or eof flushes the word; past MAX_WORDS bytes are only counted.
                            if (word_idx != MAX_W) begin
                                if (byte_cnt[1:0] == 2'd3 || bus.s_eof) begin
                                    bus.bram_wr_en   <= 1'b1;
                                    bus.bram_wr_addr <= word_idx + ADDR_W'(1);
                                    bus.bram_wr_data <= word_next;
                                    word_idx         <= word_idx + ADDR_W'(1);
                                    pack             <= '0;
                                end else begin
                                    pack <= word_next;
                                end
                            end else begin
                                ovf <= 1'b1;
                            end
                            if (bus.s_eof) state <= HDR;
                        end
                    end
                end
                HDR: begin
                    bus.bram_wr_en   <= 1'b1;
                    bus.bram_wr_addr <= '0;
                    bus.bram_wr_data <= {ovf, 20'b0, byte_cnt};
                    state            <= HOLD;
                end
                HOLD: begin
                    if (!bus.frame_valid) begin
                        bus.frame_valid <= 1'b1;
                        bus.frame_len   <= byte_cnt;
                        bus.frame_ovf   <= ovf;
                    end else if (bus.frame_ack) begin
                        bus.frame_valid <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
